// File: rtl/vga_text_renderer.sv
// Text-mode VGA renderer: generates 640x480@60 timing, fetches the character
// code for each 8x16 tile from the screen buffer, looks up the glyph row in
// the font ROM and serializes it into RGB444 with aligned sync/active flags.
// Ports:
//   clk_i, rstn_i          pixel clock, async active-low reset
//   col_r_o, row_r_o       tile address to the screen buffer (comb from counters)
//   char_i                 character code, one cycle after col_r_o/row_r_o
//   font_addr_o            font ROM address {char, glyph line} (comb)
//   font_row_i             glyph row, one cycle after font_addr_o, bit7 leftmost
//   hsync_o, vsync_o       syncs, active level SYNC_POL
//   active_o, rgb_o        visible-pixel flag and pixel colour
//   frame_start_o          pulse with pixel (0,0)
module vga_text_renderer #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [6:0]  col_r_o,
  output logic [4:0]  row_r_o,
  input  logic [6:0]  char_i,
  output logic [10:0] font_addr_o,
  input  logic [7:0]  font_row_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        active_o,
  output logic [11:0] rgb_o,
  output logic        frame_start_o
);

  localparam int unsigned HW      = 10;
  localparam int unsigned VW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_VISIBLE + H_FP;
  localparam int unsigned HS_END  = H_VISIBLE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_VISIBLE + V_FP;
  localparam int unsigned VS_END  = V_VISIBLE + V_FP + V_SYNC;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_vis, v_vis, hs_s0, vs_s0, fs_s0;

  // Stage 1/2 only keep the bits later stages consume.
  logic [2:0] h_d1, h_d2;
  logic [3:0] v_d1;
  logic       vis_d1, hs_d1, vs_d1, fs_d1;
  logic       vis_d2, hs_d2, vs_d2, fs_d2;
  logic       pixel_on;

  // Stage 0: pixel/line counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    h_vis   = (h < HW'(H_VISIBLE));
    v_vis   = (v < VW'(V_VISIBLE));
    hs_s0   = (h >= HW'(HS_BEG)) && (h < HW'(HS_END));
    vs_s0   = (v >= VW'(VS_BEG)) && (v < VW'(VS_END));
    fs_s0   = (h == '0) && (v == '0);
    // Blanking addresses are clamped to 0 so the buffer never sees out-of-range tiles.
    col_r_o = h_vis ? h[9:3] : '0;
    row_r_o = v_vis ? v[8:4] : '0;
  end

  // Stage 1: aligned with char_i from the screen buffer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_d1   <= '0;
      v_d1   <= '0;
      vis_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      fs_d1  <= 1'b0;
    end else begin
      h_d1   <= h[2:0];
      v_d1   <= v[3:0];
      vis_d1 <= h_vis && v_vis;
      hs_d1  <= hs_s0;
      vs_d1  <= vs_s0;
      fs_d1  <= fs_s0;
    end
  end

  assign font_addr_o = {char_i, v_d1};

  // Stage 2: aligned with font_row_i from the ROM.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_d2   <= '0;
      vis_d2 <= 1'b0;
      hs_d2  <= 1'b0;
      vs_d2  <= 1'b0;
      fs_d2  <= 1'b0;
    end else begin
      h_d2   <= h_d1;
      vis_d2 <= vis_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      fs_d2  <= fs_d1;
    end
  end

  // Bit 7 of the glyph row is the leftmost pixel of the tile.
  assign pixel_on = font_row_i[3'(3'd7 - h_d2)];

  // Stage 3: registered pin outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o         <= '0;
      active_o      <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
    end else begin
      rgb_o         <= vis_d2 ? (pixel_on ? FG_COLOR : BG_COLOR) : '0;
      active_o      <= vis_d2;
      hsync_o       <= hs_d2 ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vs_d2 ? SYNC_POL : ~SYNC_POL;
      frame_start_o <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer. Horizontal timing is the real 800-cycle
// line; the frame is shortened to 32 visible lines (36 total) so a run stays
// short. The last tile row is therefore row 1 instead of row 29.
module tb_vga_text_renderer;

  localparam int LINE   = 800;
  localparam int VLINES = 36;
  localparam int FRAME  = LINE * VLINES;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [6:0]  col_r_o;
  logic [4:0]  row_r_o;
  logic [6:0]  char_i;
  logic [10:0] font_addr_o;
  logic [7:0]  font_row_i;
  logic        hsync_o, vsync_o, active_o, frame_start_o;
  logic [11:0] rgb_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fs1   = 0;
  int fs2   = 0;

  logic [6:0] tile_char = 7'h20;

  vga_text_renderer #(
    .V_VISIBLE(32), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .col_r_o(col_r_o), .row_r_o(row_r_o), .char_i(char_i),
    .font_addr_o(font_addr_o), .font_row_i(font_row_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o),
    .rgb_o(rgb_o), .frame_start_o(frame_start_o)
  );

  always #20 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Screen buffer model: a few programmed tiles, everything else code 0.
  function automatic logic [6:0] buf_char(input logic [6:0] c, input logic [4:0] r,
                                          input logic [6:0] t);
    if (c == 7'd0 && r == 5'd0) return 7'h41;
    if (c == 7'd79 && r == 5'd1) return 7'h7F;
    if (c == 7'd10 && r == 5'd1) return t;
    return 7'h00;
  endfunction

  // Font ROM model.
  function automatic logic [7:0] rom_row(input logic [10:0] a);
    logic [6:0] c;
    logic [3:0] l;
    c = a[10:4];
    l = a[3:0];
    case (c)
      7'h41:   return (l == 4'd0) ? 8'hA5 : 8'h18;
      7'h7F:   return (l == 4'd15) ? 8'h01 : 8'h80;
      7'h58:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_i) begin
    char_i     <= buf_char(col_r_o, row_r_o, tile_char);
    font_row_i <= rom_row(font_addr_o);
  end

  // Sync edge recorder and whole-run invariant monitor.
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  int hfall1 = -1, hfall2 = -1, hrise = -1, vfall = -1, vrise = -1;
  int mon_n = 0, mon_bad = 0;
  always @(negedge clk_i) begin
    if (prev_hs && !hsync_o) begin
      if (hfall1 < 0) hfall1 = cyc;
      else if (hfall2 < 0) hfall2 = cyc;
    end
    if (!prev_hs && hsync_o && hfall1 >= 0 && hrise < 0) hrise = cyc;
    if (prev_vs && !vsync_o && vfall < 0) vfall = cyc;
    if (!prev_vs && vsync_o && vfall >= 0 && vrise < 0) vrise = cyc;
    prev_hs = hsync_o;
    prev_vs = vsync_o;
    mon_n++;
    if (col_r_o > 7'd79 || row_r_o > 5'd29 || (!active_o && rgb_o != 12'h000)) mon_bad++;
  end

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk_i);
  endtask

  task automatic test_reset();
    int rel;
    repeat (3) @(negedge clk_i);
    total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb_o); end
    total++; if (active_o !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active_o); end
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start_o); end
    total++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin bad++; $display("FAIL reset_sync got=%b%b want=11", hsync_o, vsync_o); end
    total++; if (col_r_o !== 7'd0 || row_r_o !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d,%0d want=0,0", col_r_o, row_r_o); end
    rstn_i = 1'b1;
    rel = cyc;
    repeat (2) @(negedge clk_i);
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL fs_early got=%b want=0 at +%0d", frame_start_o, cyc - rel); end
    @(negedge clk_i);
    total++; if (frame_start_o !== 1'b1) begin bad++; $display("FAIL fs_cycle3 got=%b want=1 at +%0d", frame_start_o, cyc - rel); end
    fs1 = cyc;
  endtask

  task automatic test_first_tile();
    logic [7:0] pat;
    logic [11:0] exp;
    pat = 8'hA5;
    for (int x = 0; x < 8; x++) begin
      goto(fs1 + x);
      exp = pat[7 - x] ? FG : BG;
      total++;
      if (rgb_o !== exp || active_o !== 1'b1) begin
        bad++; $display("FAIL first_tile_px%0d got=%h/%b want=%h/1", x, rgb_o, active_o, exp);
      end
    end
  endtask

  task automatic test_last_tile();
    goto(fs1 + 30 * LINE + 639);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL last_tile_639_30 got=%h want=%h", rgb_o, BG); end
    goto(fs1 + 31 * LINE + 632);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL last_tile_632 got=%h want=%h", rgb_o, BG); end
    goto(fs1 + 31 * LINE + 638);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL last_tile_638 got=%h want=%h", rgb_o, BG); end
    goto(fs1 + 31 * LINE + 639);
    total++; if (rgb_o !== FG || active_o !== 1'b1) begin bad++; $display("FAIL last_tile_639 got=%h/%b want=%h/1", rgb_o, active_o, FG); end
    goto(fs1 + 31 * LINE + 640);
    total++; if (rgb_o !== 12'h000 || active_o !== 1'b0) begin bad++; $display("FAIL after_last got=%h/%b want=000/0", rgb_o, active_o); end
  endtask

  task automatic test_sync();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 1000 && !seen; i++) begin
      @(negedge clk_i);
      if (frame_start_o) seen = 1'b1;
    end
    fs2 = seen ? cyc : fs1 + FRAME;
    total++; if (!seen || fs2 - fs1 != FRAME) begin bad++; $display("FAIL frame_period got=%0d want=%0d", seen ? fs2 - fs1 : -1, FRAME); end
    total++; if (hfall1 - fs1 != 656) begin bad++; $display("FAIL hsync_offset got=%0d want=656", hfall1 - fs1); end
    total++; if (hfall2 - hfall1 != LINE) begin bad++; $display("FAIL hsync_period got=%0d want=%0d", hfall2 - hfall1, LINE); end
    total++; if (hrise - hfall1 != 96) begin bad++; $display("FAIL hsync_width got=%0d want=96", hrise - hfall1); end
    total++; if (vfall - fs1 != 33 * LINE) begin bad++; $display("FAIL vsync_offset got=%0d want=%0d", vfall - fs1, 33 * LINE); end
    total++; if (vrise - vfall != 2 * LINE) begin bad++; $display("FAIL vsync_width got=%0d want=%0d", vrise - vfall, 2 * LINE); end
  endtask

  task automatic test_tile_update();
    goto(fs2 + 20 * LINE + 80);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL old_glyph_80 got=%h want=%h", rgb_o, BG); end
    goto(fs2 + 20 * LINE + 87);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL old_glyph_87 got=%h want=%h", rgb_o, BG); end
    goto(fs2 + 20 * LINE + 400);
    tile_char = 7'h58;
    goto(fs2 + 21 * LINE + 80);
    total++; if (rgb_o !== FG) begin bad++; $display("FAIL new_glyph_80 got=%h want=%h", rgb_o, FG); end
    goto(fs2 + 21 * LINE + 87);
    total++; if (rgb_o !== FG) begin bad++; $display("FAIL new_glyph_87 got=%h want=%h", rgb_o, FG); end
    goto(fs2 + 21 * LINE + 88);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL neighbour_88 got=%h want=%h", rgb_o, BG); end
    goto(fs2 + 24 * LINE + 84);
    total++; if (rgb_o !== FG) begin bad++; $display("FAIL new_glyph_l24 got=%h want=%h", rgb_o, FG); end
  endtask

  task automatic test_mid_reset();
    int rel;
    goto(fs2 + 27 * LINE + 300);
    total++; if (active_o !== 1'b1) begin bad++; $display("FAIL pre_reset_active got=%b want=1", active_o); end
    rstn_i = 1'b0;
    #1;
    total++; if (rgb_o !== 12'h000 || active_o !== 1'b0) begin bad++; $display("FAIL midrst_px got=%h/%b want=000/0", rgb_o, active_o); end
    total++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1 || frame_start_o !== 1'b0) begin bad++; $display("FAIL midrst_sync got=%b%b%b want=110", hsync_o, vsync_o, frame_start_o); end
    repeat (5) @(negedge clk_i);
    total++; if (rgb_o !== 12'h000 || active_o !== 1'b0) begin bad++; $display("FAIL midrst_hold got=%h/%b want=000/0", rgb_o, active_o); end
    rstn_i = 1'b1;
    rel = cyc;
    repeat (2) @(negedge clk_i);
    total++; if (frame_start_o !== 1'b0 || active_o !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b/%b want=0/0", frame_start_o, active_o); end
    @(negedge clk_i);
    total++; if (frame_start_o !== 1'b1 || cyc - rel != 3) begin bad++; $display("FAIL midrst_fs got=%b at +%0d want=1 at +3", frame_start_o, cyc - rel); end
    total++; if (rgb_o !== FG || active_o !== 1'b1) begin bad++; $display("FAIL midrst_px0 got=%h/%b want=%h/1", rgb_o, active_o, FG); end
    @(negedge clk_i);
    total++; if (rgb_o !== BG) begin bad++; $display("FAIL midrst_px1 got=%h want=%h", rgb_o, BG); end
  endtask

  task automatic test_monitor();
    total++; if (mon_bad != 0) begin bad++; $display("FAIL monitor_violations got=%0d want=0", mon_bad); end
    total++; if (mon_n < 40000) begin bad++; $display("FAIL monitor_coverage got=%0d want>=40000", mon_n); end
  endtask

  initial begin
    test_reset();
    test_first_tile();
    test_last_tile();
    test_sync();
    test_tile_update();
    test_mid_reset();
    test_monitor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
